seq_mult5: RTL and testbench



---
 rtl/seq_mult5.sv | 61 ++++++
 tb/tb_seq_mult5.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult5.sv
// Sequential 5x5 unsigned shift-and-add multiplier; captures operands on start,
// one partial-product add per clock, 10-bit product with a one-cycle done pulse.
module seq_mult5 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] in_a,
  input  logic [4:0] in_b,
  output logic [9:0] out_p,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  a;
  logic [10:0] p;
  logic [2:0]  cnt;
  logic [5:0]  sum6;

  // Accumulator plus carry fits in 6 bits: at most 31 + 31 = 62.
  assign sum6 = p[10:5] + (p[0] ? {1'b0, a} : 6'b0);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a     <= 5'd0;
      p     <= 11'd0;
      cnt   <= 3'd0;
      out_p <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a     <= in_a;
            p     <= {6'b0, in_b};
            cnt   <= 3'd0;
            state <= RUN;
          end
        end
        RUN: begin
          p   <= {1'b0, sum6, p[4:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            state <= DONE;
            out_p <= {sum6, p[4:1]};
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult5.sv
// Directed and exhaustive checks for seq_mult5: latency, product, pulse shape, reset abort.
module tb_seq_mult5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] in_a = 5'd0;
  logic [4:0] in_b = 5'd0;
  logic [9:0] out_p;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_mult5 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .out_p (out_p),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [9:0] p;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // busy and done must never overlap
  always @(negedge clk) begin
    if (!reset) chk("busy_done_excl", int'(busy & done), 0);
  end

  // One full operation from IDLE; returns to IDLE and samples at a negedge.
  task automatic do_op(input logic [4:0] a, input logic [4:0] b,
                       input logic [9:0] exp, input string nm);
    int lat;
    int bcnt;
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 10) begin
      if (busy) bcnt++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 5);
    chk({nm, "_busy_cycles"}, bcnt, 5);
    chk({nm, "_prod"}, int'(out_p), int'(exp));
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, int'(done), 0);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    int last;
    int pulses;
    int seen;

    vecs[0] = '{5'd31, 5'd31, 10'd961};
    vecs[1] = '{5'd0,  5'd27, 10'd0};
    vecs[2] = '{5'd19, 5'd0,  10'd0};
    vecs[3] = '{5'd1,  5'd31, 10'd31};
    vecs[4] = '{5'd13, 5'd11, 10'd143};
    vecs[5] = '{5'd9,  5'd9,  10'd81};
    vecs[6] = '{5'd2,  5'd3,  10'd6};
    vecs[7] = '{5'd17, 5'd5,  10'd85};
    vecs[8] = '{5'd16, 5'd16, 10'd256};
    vecs[9] = '{5'd31, 5'd1,  10'd31};

    #1;
    chk("reset_out_p", int'(out_p), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Operands and start changing during RUN are ignored
    @(negedge clk);
    in_a = 5'd5; in_b = 5'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_a = 5'd31; in_b = 5'd31;
    n = 0;
    while (!done && n < 10) begin
      chk("ignore_busy_held", int'(busy), 1);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("ignore_latency", n, 5);
    chk("ignore_prod", int'(out_p), 30);
    @(posedge clk);
    @(negedge clk);
    chk("ignore_idle_after_done", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);

    // Start held continuously: one product every 7 edges
    in_a = 5'd3; in_b = 5'd7; start = 1'b1;
    last = 0; pulses = 0; seen = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (seen != 0) chk("cont_period", cyc - last, 7);
        else chk("cont_first_pulse", cyc, 6);
        chk("cont_prod", int'(out_p), 21);
        last = cyc;
        seen = 1;
        pulses++;
      end else if (seen != 0) begin
        chk("cont_stable", int'(out_p), 21);
      end
    end
    chk("cont_pulses", pulses, 4);
    start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("cont_drain_done", int'(done), 1);
    @(posedge clk);
    @(negedge clk);

    // Reset mid-operation aborts immediately
    do_op(5'd9, 5'd9, 10'd81, "pre_abort");
    @(negedge clk);
    in_a = 5'd31; in_b = 5'd31; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_out_p", int'(out_p), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      chk("abort_no_busy", int'(busy), 0);
    end
    do_op(5'd2, 5'd3, 10'd6, "post_abort");

    // Exhaustive sweep
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        do_op(5'(x), 5'(y), 10'(x * y), $sformatf("sweep_%0d_%0d", x, y));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
